mac8x8: RTL and testbench
=========================

// Module: mac8x8
// PURPOSE
//   Pipelined unsigned 8x8 multiply-accumulate. Each clock, x*y is registered;
//   the registered product is added to a running accumulator on the next clock.
//   dataout is the accumulator register. Used as a leaf datapath block fed by a
//   vector source that changes operands on the falling clock edge.
// PARAMETERS
//   DSIZE  8   operand width (x, y), unsigned
//   OSIZE  16  product width; accumulator/dataout is OSIZE+1 bits
// PORTS
//   clk      in   1          single clock, all state on rising edge
//   rst      in   1          asynchronous, active-low reset
//   x        in   DSIZE      multiplicand, unsigned
//   y        in   DSIZE      multiplier, unsigned
//   dataout  out  OSIZE+1    accumulator value (registered)
// BEHAVIOUR
//   - Reset (rst=0, async): prod_q <= 0, acc_q <= 0; dataout = 0 immediately.
//     Reset has priority over every clock edge and is held until rst=1.
//   - Each rising edge with rst=1: prod_q <= x*y (full OSIZE bits, no truncation);
//     acc_q <= acc_q + zero_ext(prod_q).
//   - Latency: operands sampled at edge N appear in dataout after edge N+1.
//     After edge k, dataout = sum of products sampled at edges 1..k-1 since reset.
//   - Width: sum computed in OSIZE+1 bits; overflow wraps modulo 2^(OSIZE+1)
//     (default build). No carry-out port.
//   - Zero operands contribute 0; dataout holds its value.
//   - Reset mid-stream also clears prod_q: the first edge after release adds 0.
//   - dataout never X after reset; no handshake, accepts one operand pair per cycle.
// CONFIGURATION
//   MAC8X8_SATURATE_EN: if defined, accumulator saturates at 2^(OSIZE+1)-1
//   (all ones) instead of wrapping; once saturated it holds until reset.
//   Undefined: modulo wrap-around as above.
// STRUCTURE
//   Package mac8x8_pkg: DSIZE/OSIZE defaults, ACC_W = OSIZE+1, ACC_MAX constant.
//   Sub-module mac8x8_mult: registered unsigned multiplier (x,y -> prod_q) with
//   async active-low clear. Top holds the accumulator register and the
//   wrap/saturate adder.
// TESTING
//   1. rst=0 at start -> dataout = 0 at and after the first rising edge.
//   2. Release rst; apply (2,5),(5,4),(7,9),(17,0),(11,11),(1,100),(0,255)
//      -> dataout after each edge: 0,10,30,93,93,214,314.
//   3. Continue with (255,255),(255,255) -> dataout 314 then 65339 (0x0FF3B).
//   4. Wrap: from reset apply (255,255) x3 then zeros -> dataout after 4th edge
//      = 195075 mod 131072 = 64003; with MAC8X8_SATURATE_EN -> 131071 and holds.
//   5. Async reset mid-run: drop rst between edges -> dataout 0 without a clock;
//      release, apply (3,3) -> dataout 0 after first edge, 9 after second.
//   6. Self-check each cycle that dataout is never X/Z after reset release.

Source files
------------

// File: rtl/mac8x8_pkg.sv
// Shared widths and constants for the mac8x8 multiply-accumulate slice.
// The MAC8X8_SATURATE_EN build option is handled in mac8x8.sv.
package mac8x8_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int OSIZE_DEF = 16;
  localparam int ACC_W     = OSIZE_DEF + 1;

  // All-ones accumulator value, used as the saturation ceiling
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

endpackage

// File: rtl/mac8x8_mult.sv
// Registered unsigned multiplier: prod is x*y captured on each rising edge,
// cleared asynchronously while rst is low.
module mac8x8_mult
  import mac8x8_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int OSIZE = OSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] x,
  input  logic [DSIZE-1:0] y,
  output logic [OSIZE-1:0] prod
);

  logic [OSIZE-1:0] full_prod;

  // Operands are widened before the multiply so no product bits are lost
  assign full_prod = OSIZE'(x) * OSIZE'(y);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod <= '0;
    end else begin
      prod <= full_prod;
    end
  end

endmodule

// File: rtl/mac8x8.sv
// Pipelined unsigned multiply-accumulate: product register feeds an OSIZE+1 bit
// accumulator. Define MAC8X8_SATURATE_EN to clamp at all ones instead of wrapping.
module mac8x8
  import mac8x8_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int OSIZE = OSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] x,
  input  logic [DSIZE-1:0] y,
  output logic [OSIZE:0]   dataout
);

  logic [OSIZE-1:0] prod_q;
  logic [OSIZE:0]   acc_q;
  logic [OSIZE:0]   acc_next;

  mac8x8_mult #(
    .DSIZE (DSIZE),
    .OSIZE (OSIZE)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .y    (y),
    .prod (prod_q)
  );

`ifdef MAC8X8_SATURATE_EN
  logic [OSIZE+1:0] sum;

  // One extra bit catches the carry; any carry means the true sum exceeds all ones
  always_comb begin
    sum      = {1'b0, acc_q} + {2'b00, prod_q};
    acc_next = acc_q;
    if (sum[OSIZE+1]) begin
      acc_next = '1;
    end else begin
      acc_next = sum[OSIZE:0];
    end
  end
`else
  always_comb begin
    acc_next = acc_q + {1'b0, prod_q};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_next;
    end
  end

  assign dataout = acc_q;

endmodule

// File: tb/tb_mac8x8.sv
// Self-checking bench for mac8x8: directed vector table, wrap/saturate and
// async-reset sequences, then random operands against a sum-of-products model.
module tb_mac8x8;
  import mac8x8_pkg::*;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [16:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [16:0] dataout;

  int checks;
  int errors;

  // Every product the DUT has sampled since the last reset, oldest first
  int unsigned hist[$];

  mac8x8 dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .y       (y),
    .dataout (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After edge k the accumulator holds the products sampled at edges 1..k-1
  function automatic logic [16:0] modelExpected();
    longint s;
    s = 0;
    for (int i = 0; i < int'(hist.size()) - 1; i++) s += hist[i];
`ifdef MAC8X8_SATURATE_EN
    if (s > longint'(ACC_MAX)) s = longint'(ACC_MAX);
`else
    s = s % 131072;
`endif
    return s[16:0];
  endfunction

  task automatic checkOutput(input string name, input logic [16:0] exp);
    checks++;
    if ($isunknown(dataout) || dataout !== exp) begin
      errors++;
      $display("[TB] FAIL %s: dataout=%0d expected=%0d", name, dataout, exp);
    end
  endtask

  // Operands change on the falling edge, then the rising edge samples them
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    x = a;
    y = b;
    @(posedge clk);
    hist.push_back(int'(a) * int'(b));
    #1;
  endtask

  // Reset asserted for one edge, released between edges so the next edge is the first
  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    x   = 8'd0;
    y   = 8'd0;
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 17'd0);
    #2;
    rst = 1'b1;
    hist.delete();
  endtask

  vec_t tbl[9];
  logic [16:0] wrap_exp;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    x      = 8'd37;
    y      = 8'd91;

    tbl[0] = '{x: 8'd2,   y: 8'd5,   exp: 17'd0};
    tbl[1] = '{x: 8'd5,   y: 8'd4,   exp: 17'd10};
    tbl[2] = '{x: 8'd7,   y: 8'd9,   exp: 17'd30};
    tbl[3] = '{x: 8'd17,  y: 8'd0,   exp: 17'd93};
    tbl[4] = '{x: 8'd11,  y: 8'd11,  exp: 17'd93};
    tbl[5] = '{x: 8'd1,   y: 8'd100, exp: 17'd214};
    tbl[6] = '{x: 8'd0,   y: 8'd255, exp: 17'd314};
    tbl[7] = '{x: 8'd255, y: 8'd255, exp: 17'd314};
    tbl[8] = '{x: 8'd255, y: 8'd255, exp: 17'd65339};

    // Held in reset from time zero with nonzero operands present
    #1;
    checkOutput("reset_t0", 17'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_edge1", 17'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_edge2", 17'd0);
    #2;
    rst = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].x, tbl[i].y);
      checkOutput($sformatf("table_%0d", i), tbl[i].exp);
    end

    $display("[TB] overflow sequence");
`ifdef MAC8X8_SATURATE_EN
    wrap_exp = 17'd131071;
`else
    wrap_exp = 17'd64003;
`endif
    doReset();
    applyStimulus(8'd255, 8'd255);
    checkOutput("wrap_e1", 17'd0);
    applyStimulus(8'd255, 8'd255);
    checkOutput("wrap_e2", 17'd65025);
    applyStimulus(8'd255, 8'd255);
    checkOutput("wrap_e3", 17'd130050);
    applyStimulus(8'd0, 8'd0);
    checkOutput("wrap_e4", wrap_exp);
    applyStimulus(8'd0, 8'd0);
    checkOutput("wrap_hold", wrap_exp);

    $display("[TB] async reset mid-run");
    doReset();
    applyStimulus(8'd50, 8'd60);
    applyStimulus(8'd70, 8'd80);
    checkOutput("pre_async", 17'd3000);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_clear", 17'd0);
    #1;
    rst = 1'b1;
    x   = 8'd3;
    y   = 8'd3;
    hist.delete();
    @(posedge clk);
    hist.push_back(9);
    #1;
    checkOutput("async_first", 17'd0);
    applyStimulus(8'd0, 8'd0);
    checkOutput("async_second", 17'd9);

    $display("[TB] random operands against model");
    doReset();
    for (int n = 0; n < 300; n++) begin
      logic [7:0] a;
      logic [7:0] b;
      case ($urandom_range(0, 5))
        0:       begin a = 8'd0;   b = 8'($urandom); end
        1:       begin a = 8'd255; b = 8'd255;       end
        default: begin a = 8'($urandom); b = 8'($urandom); end
      endcase
      applyStimulus(a, b);
      checkOutput("random", modelExpected());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
